// File: rtl/router_pkg.sv
// Shared types and width helpers for the N-channel FIFO router.
package router_pkg;

  // Input-side policy when the target channel FIFO is full.
  typedef enum logic {
    MODE_BACKPRESSURE = 1'b0,
    MODE_DROP         = 1'b1
  } mode_e;

  // Ceiling log2 that never returns less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

  // Width of the channel address field carried in the MSBs of each word.
  function automatic int unsigned addr_width(input int unsigned num_ch);
    return clog2_min1(num_ch);
  endfunction

  // Width of a fill level that must represent 0..depth inclusive.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_nch_if.sv
// Input stream plus per-channel output streams and status of the router.
interface router_nch_if
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAYLOAD_W  = 8,
  parameter int unsigned CNT_W      = 16
);

  localparam int unsigned ADDR_W = addr_width(NUM_CH);
  localparam int unsigned LVL_W  = lvl_width(FIFO_DEPTH);

  logic                                valid_i;
  logic                                ready_o;
  logic [ADDR_W+PAYLOAD_W-1:0]         data_i;
  logic [NUM_CH-1:0]                   valid_o;
  logic [NUM_CH-1:0]                   ready_i;
  logic [NUM_CH-1:0][PAYLOAD_W-1:0]    data_o;
  logic [NUM_CH-1:0]                   full_o;
  logic [NUM_CH-1:0][LVL_W-1:0]        level_o;
  logic [CNT_W-1:0]                    drop_cnt_o;
  logic [CNT_W-1:0]                    err_cnt_o;

  // Producer and channel consumers.
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, full_o, level_o, drop_cnt_o, err_cnt_o
  );

  // The router itself.
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, full_o, level_o, drop_cnt_o, err_cnt_o
  );

endinterface

// File: rtl/router_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; one per channel.
module router_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level_c,
  output logic [W-1:0]               head_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full_c  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty_c = (wr_ptr == rd_ptr);
  assign level_c = wr_ptr - rd_ptr;
  assign head_c  = mem[rd_ptr[AW-1:0]];

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Pointer update; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write, unreset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/router_nch.sv
// Steers one valid/ready stream to NUM_CH channel FIFOs by address MSBs.
module router_nch
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PAYLOAD_W    = 8,
  parameter int unsigned DROP_ON_FULL = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  router_nch_if.slave bus
);

  localparam int unsigned ADDR_W = addr_width(NUM_CH);
  localparam int unsigned LVL_W  = lvl_width(FIFO_DEPTH);
  localparam int unsigned NSLOT  = 1 << ADDR_W;
  localparam mode_e       MODE   = (DROP_ON_FULL != 0) ? MODE_DROP : MODE_BACKPRESSURE;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] payload;
  } word_t;

  word_t                          word;
  logic                           addr_ok;
  logic                           target_full;
  logic                           push_en;
  logic                           drop_ev;
  logic                           err_ev;
  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH-1:0]              push;
  logic [NUM_CH-1:0]              pop;
  logic [NSLOT-1:0]               full_slot;
  logic [NUM_CH-1:0][LVL_W-1:0]   level;
  logic [NUM_CH-1:0][PAYLOAD_W-1:0] head;
  logic [CNT_W-1:0]               drop_cnt;
  logic [CNT_W-1:0]               err_cnt;

  assign word = bus.data_i;

  // Decode: out-of-range addresses are accepted and discarded.
  assign addr_ok     = ({1'b0, word.addr} < (ADDR_W+1)'(NUM_CH));
  assign full_slot   = NSLOT'(full);
  assign target_full = full_slot[word.addr];

  // Ready never looks at the consumer side, only at the target full flag.
  assign bus.ready_o = (MODE == MODE_DROP) ? 1'b1 : (!addr_ok || !target_full);

  assign push_en = bus.valid_i && addr_ok && !target_full;
  assign drop_ev = (MODE == MODE_DROP) && bus.valid_i && addr_ok && target_full;
  assign err_ev  = bus.valid_i && !addr_ok;

  // One FIFO per channel, each popped independently by its consumer.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = push_en && (word.addr == ADDR_W'(c));
    assign pop[c]  = !empty[c] && bus.ready_i[c];

    router_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PAYLOAD_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push[c]),
      .pop     (pop[c]),
      .wdata   (word.payload),
      .full_c  (full[c]),
      .empty_c (empty[c]),
      .level_c (level[c]),
      .head_c  (head[c])
    );
  end

  // Saturating drop and error counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (drop_ev && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (err_ev && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.valid_o    = ~empty;
  assign bus.data_o     = head;
  assign bus.full_o     = full;
  assign bus.level_o    = level;
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_router_nch.sv
// Three routers (4ch backpressure, 4ch drop, 3ch backpressure) share one
// stimulus stream; each is checked every cycle against a queue model.
module tb_router_nch;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       v_in = 1'b0;
  logic [9:0] d_in = '0;
  logic [3:0] rdy_in = '0;

  int vectors = 0;
  int miscompares = 0;

  // Model state: per instance, per channel queue of payloads.
  logic [7:0] mq [3][4][$];
  int dcnt [3];
  int ecnt [3];
  int nch  [3] = '{4, 4, 3};
  bit dmode[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  router_nch_if #(.NUM_CH(4), .FIFO_DEPTH(4), .PAYLOAD_W(8), .CNT_W(16)) if_bp ();
  router_nch_if #(.NUM_CH(4), .FIFO_DEPTH(4), .PAYLOAD_W(8), .CNT_W(16)) if_dr ();
  router_nch_if #(.NUM_CH(3), .FIFO_DEPTH(4), .PAYLOAD_W(8), .CNT_W(16)) if_n3 ();

  assign if_bp.valid_i = v_in;
  assign if_bp.data_i  = d_in;
  assign if_bp.ready_i = rdy_in;
  assign if_dr.valid_i = v_in;
  assign if_dr.data_i  = d_in;
  assign if_dr.ready_i = rdy_in;
  assign if_n3.valid_i = v_in;
  assign if_n3.data_i  = d_in;
  assign if_n3.ready_i = rdy_in[2:0];

  router_nch #(.NUM_CH(4), .FIFO_DEPTH(4), .PAYLOAD_W(8), .DROP_ON_FULL(0), .CNT_W(16))
    u_bp (.clk_i(clk), .rst_i(rst_in), .bus(if_bp.slave));
  router_nch #(.NUM_CH(4), .FIFO_DEPTH(4), .PAYLOAD_W(8), .DROP_ON_FULL(1), .CNT_W(16))
    u_dr (.clk_i(clk), .rst_i(rst_in), .bus(if_dr.slave));
  router_nch #(.NUM_CH(3), .FIFO_DEPTH(4), .PAYLOAD_W(8), .DROP_ON_FULL(0), .CNT_W(16))
    u_n3 (.clk_i(clk), .rst_i(rst_in), .bus(if_n3.slave));

  task automatic cmp(input string nm, input int k, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d ch%0d: got %0h expected %0h at %0t", nm, k, c, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int k);
    int a;
    a = int'(d_in[9:8]);
    if (dmode[k]) return 1'b1;
    if (a >= nch[k]) return 1'b1;
    return mq[k][a].size() < 4;
  endfunction

  task automatic check_inst(input int k, input logic [3:0] valid, input logic [3:0] full,
                            input logic rdy, input logic [3:0][7:0] data,
                            input logic [3:0][2:0] lvl, input logic [15:0] dc,
                            input logic [15:0] ec);
    logic [3:0] ev;
    logic [3:0] ef;
    ev = '0;
    ef = '0;
    for (int c = 0; c < nch[k]; c++) begin
      ev[c] = mq[k][c].size() > 0;
      ef[c] = mq[k][c].size() == 4;
      cmp("level", k, c, 32'(lvl[c]), 32'(mq[k][c].size()));
      if (mq[k][c].size() > 0) cmp("data", k, c, 32'(data[c]), 32'(mq[k][c][0]));
    end
    cmp("valid", k, 0, 32'(valid), 32'(ev));
    cmp("full", k, 0, 32'(full), 32'(ef));
    cmp("ready", k, 0, 32'(rdy), 32'(exp_ready(k)));
    cmp("drop_cnt", k, 0, 32'(dc), 32'(dcnt[k]));
    cmp("err_cnt", k, 0, 32'(ec), 32'(ecnt[k]));
  endtask

  task automatic check_all();
    check_inst(0, if_bp.valid_o, if_bp.full_o, if_bp.ready_o, if_bp.data_o,
               if_bp.level_o, if_bp.drop_cnt_o, if_bp.err_cnt_o);
    check_inst(1, if_dr.valid_o, if_dr.full_o, if_dr.ready_o, if_dr.data_o,
               if_dr.level_o, if_dr.drop_cnt_o, if_dr.err_cnt_o);
    check_inst(2, {1'b0, if_n3.valid_o}, {1'b0, if_n3.full_o}, if_n3.ready_o,
               {8'h00, if_n3.data_o}, {3'b000, if_n3.level_o},
               if_n3.drop_cnt_o, if_n3.err_cnt_o);
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst_in) begin
        for (int c = 0; c < 4; c++) mq[k][c].delete();
        dcnt[k] = 0;
        ecnt[k] = 0;
      end else begin
        int a;
        bit pushw;
        a = int'(d_in[9:8]);
        pushw = 1'b0;
        if (v_in) begin
          if (a >= nch[k]) begin
            if (ecnt[k] < 65535) ecnt[k]++;
          end else if (mq[k][a].size() < 4) begin
            pushw = 1'b1;
          end else if (dmode[k]) begin
            if (dcnt[k] < 65535) dcnt[k]++;
          end
        end
        for (int c = 0; c < nch[k]; c++)
          if (mq[k][c].size() > 0 && rdy_in[c]) void'(mq[k][c].pop_front());
        if (pushw) mq[k][a].push_back(d_in[7:0]);
      end
    end
  endtask

  // Called at a falling edge; leaves time 1 unit later with inputs settled.
  task automatic drive(input bit v, input logic [9:0] d, input logic [3:0] rdy, input bit r);
    v_in = v;
    d_in = d;
    rdy_in = rdy;
    rst_in = r;
    #1;
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b1);
    tick();
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    logic [7:0] tbl [4];
    int sent;
    int cyc;
    bit have;
    bit acc;
    logic cur_v;
    logic [9:0] cur_d;

    // Initial reset: DUT state is unknown before it, so no checks yet.
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);

    // One word to each channel; the 3-channel router sees addr 3 as invalid.
    tbl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {2'(i), tbl[i]}, 4'b0000, 1'b0);
      tick();
    end
    drive(1'b0, '0, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cmp("p1_data", 0, c, 32'(if_bp.data_o[c]), 32'(tbl[c]));
      cmp("p1_level", 0, c, 32'(if_bp.level_o[c]), 32'd1);
    end
    cmp("p1_n3_err", 2, 0, 32'(if_n3.err_cnt_o), 32'd1);
    cmp("p1_n3_valid", 2, 0, 32'(if_n3.valid_o), 32'h7);
    tick();

    // Backpressure on channel 2: fifth word held until a pop frees space.
    do_reset();
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {2'd2, tbl[i]}, 4'b0000, 1'b0);
      tick();
    end
    drive(1'b1, {2'd2, 8'h55}, 4'b0000, 1'b0);
    cmp("p2_ready_full", 0, 2, 32'(if_bp.ready_o), 32'd0);
    cmp("p2_full", 0, 2, 32'(if_bp.full_o[2]), 32'd1);
    tick();
    drive(1'b1, {2'd2, 8'h55}, 4'b0100, 1'b0);
    cmp("p2_ready_pop", 0, 2, 32'(if_bp.ready_o), 32'd0);
    tick();
    drive(1'b1, {2'd2, 8'h55}, 4'b0000, 1'b0);
    cmp("p2_ready_after", 0, 2, 32'(if_bp.ready_o), 32'd1);
    tick();
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p2_level", 0, 2, 32'(if_bp.level_o[2]), 32'd4);
    cmp("p2_drop_cnt", 1, 0, 32'(if_dr.drop_cnt_o), 32'd2);
    tick();
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 4'b0100, 1'b0);
      cmp("p2_order", 0, 2, 32'(if_bp.data_o[2]), 32'(exp_seq[i]));
      tick();
    end
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p2_drained", 0, 2, 32'(if_bp.valid_o[2]), 32'd0);
    tick();

    // Drop mode: six words to channel 0, two discarded.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, {2'd0, 8'(8'h61 + i)}, 4'b0000, 1'b0);
      cmp("p3_dr_ready", 1, 0, 32'(if_dr.ready_o), 32'd1);
      tick();
    end
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p3_level", 1, 0, 32'(if_dr.level_o[0]), 32'd4);
    cmp("p3_drop_cnt", 1, 0, 32'(if_dr.drop_cnt_o), 32'd2);
    cmp("p3_head", 1, 0, 32'(if_dr.data_o[0]), 32'h61);
    tick();

    // Three-channel router: invalid address then a valid one.
    do_reset();
    drive(1'b1, {2'd3, 8'h5A}, 4'b0000, 1'b0);
    cmp("p4_ready", 2, 0, 32'(if_n3.ready_o), 32'd1);
    tick();
    drive(1'b1, {2'd2, 8'h77}, 4'b0000, 1'b0);
    cmp("p4_novalid", 2, 0, 32'(if_n3.valid_o), 32'd0);
    tick();
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p4_err", 2, 0, 32'(if_n3.err_cnt_o), 32'd1);
    cmp("p4_valid", 2, 0, 32'(if_n3.valid_o), 32'h4);
    cmp("p4_data", 2, 2, 32'(if_n3.data_o[2]), 32'h77);
    tick();

    // Push and pop together at level 1 and level 2.
    do_reset();
    drive(1'b1, {2'd1, 8'h10}, 4'b0000, 1'b0); tick();
    drive(1'b1, {2'd1, 8'h20}, 4'b0010, 1'b0); tick();
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p6_lvl1", 0, 1, 32'(if_bp.level_o[1]), 32'd1);
    cmp("p6_head1", 0, 1, 32'(if_bp.data_o[1]), 32'h20);
    drive(1'b1, {2'd1, 8'h30}, 4'b0000, 1'b0); tick();
    drive(1'b1, {2'd1, 8'h40}, 4'b0010, 1'b0); tick();
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p6_lvl2", 0, 1, 32'(if_bp.level_o[1]), 32'd2);
    cmp("p6_head2", 0, 1, 32'(if_bp.data_o[1]), 32'h30);
    tick();

    // Random streaming; the word is held until the backpressure router takes it.
    do_reset();
    sent = 0;
    cyc = 0;
    have = 1'b0;
    cur_v = 1'b0;
    cur_d = '0;
    while (sent < 200 && cyc < 4000) begin
      if (!have) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_d = 10'($urandom);
      end
      drive(cur_v, cur_d, 4'($urandom) | 4'($urandom), 1'b0);
      acc = cur_v && if_bp.ready_o;
      tick();
      if (acc) sent++;
      have = cur_v && !acc;
      cyc++;
    end
    cmp("stream_budget", 0, 0, 32'(sent >= 200), 32'd1);

    // Reset mid-stream with channel 1 holding three words.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {2'd1, 8'(8'h90 + i)}, 4'b0000, 1'b0);
      tick();
    end
    drive(1'b1, {2'd1, 8'h99}, 4'b1111, 1'b1);
    cmp("p7_lvl3", 0, 1, 32'(if_bp.level_o[1]), 32'd3);
    tick();
    drive(1'b0, '0, 4'b0000, 1'b0);
    cmp("p7_levels", 0, 0, 32'(if_bp.level_o), 32'd0);
    cmp("p7_valid", 0, 0, 32'(if_bp.valid_o), 32'd0);
    cmp("p7_cnt", 1, 0, 32'(if_dr.drop_cnt_o), 32'd0);
    tick();
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 10'($urandom), 4'($urandom), 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
